// File: rtl/zero_count_normalizer_if.sv
// Stream bundle for the zero-count normaliser:
// input word with mode, result with count/shift/zero flag.
interface zero_count_normalizer_if #(
  parameter int Width      = 24,
  parameter int CountWidth = $clog2(Width + 1)
) ();
  logic                  valid_i;
  logic                  ready_o;
  logic [Width-1:0]      data_i;
  logic                  mode_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [CountWidth-1:0] count_o;
  logic [Width-1:0]      shifted_o;
  logic                  zero_o;
  logic                  mode_o;

  modport master (
    output valid_i, data_i, mode_i, ready_i,
    input  ready_o, valid_o, count_o,
    input  shifted_o, zero_o, mode_o
  );

  modport slave (
    input  valid_i, data_i, mode_i, ready_i,
    output ready_o, valid_o, count_o,
    output shifted_o, zero_o, mode_o
  );
endinterface

// File: rtl/zero_count_normalizer.sv
// Two-stage leading/trailing zero counter with normalising shift
// and valid/ready backpressure on both stages.
module zero_count_normalizer #(
  parameter int Width      = 24,
  parameter int CountWidth = $clog2(Width + 1)
) (
  input  logic clk,
  input  logic reset,
  zero_count_normalizer_if.slave bus
);

  logic                  s1_valid_q, s1_valid_d;
  logic [Width-1:0]      s1_data_q, s1_data_d;
  logic                  s1_mode_q, s1_mode_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [Width-1:0]      shifted_q, shifted_d;
  logic                  zero_q, zero_d;
  logic                  mode_q, mode_d;

  logic                  s1_adv;
  logic                  s2_adv;
  logic [CountWidth-1:0] cnt;
  logic [Width-1:0]      shf;

  // An all-zero word falls through both loops and keeps cnt = Width.
  always_comb begin
    cnt = CountWidth'(Width);
    shf = '0;
    unique case (1'b1)
      s1_mode_q: begin
        for (int i = 0; i < Width; i++)
          if (s1_data_q[i]) cnt = CountWidth'(Width - 1 - i);
        shf = s1_data_q << cnt;
      end
      !s1_mode_q: begin
        for (int i = Width - 1; i >= 0; i--)
          if (s1_data_q[i]) cnt = CountWidth'(i);
        shf = s1_data_q >> cnt;
      end
    endcase
  end

  always_comb begin
    s2_adv     = ~s2_valid_q | bus.ready_i;
    s1_adv     = ~s1_valid_q | s2_adv;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    count_d    = count_q;
    shifted_d  = shifted_q;
    zero_d     = zero_q;
    mode_d     = mode_q;
    if (s1_adv) begin
      s1_valid_d = bus.valid_i;
      if (bus.valid_i) begin
        s1_data_d = bus.data_i;
        s1_mode_d = bus.mode_i;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        count_d   = cnt;
        shifted_d = shf;
        zero_d    = ~|s1_data_q;
        mode_d    = s1_mode_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      count_q    <= '0;
      shifted_q  <= '0;
      zero_q     <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      count_q    <= count_d;
      shifted_q  <= shifted_d;
      zero_q     <= zero_d;
      mode_q     <= mode_d;
    end
  end

  assign bus.ready_o   = s1_adv;
  assign bus.valid_o   = s2_valid_q;
  assign bus.count_o   = count_q;
  assign bus.shifted_o = shifted_q;
  assign bus.zero_o    = zero_q;
  assign bus.mode_o    = mode_q;

endmodule

// File: tb/tb_zero_count_normalizer.sv
// Directed bench: three normaliser instances (24, 53, 2 bits)
// driven in lockstep, with a per-width scoreboard.
module tb_zero_count_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        mode_i;
  logic        ready_i;
  logic [63:0] din;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  zero_count_normalizer_if #(.Width(24)) if24 ();
  zero_count_normalizer_if #(.Width(53)) if53 ();
  zero_count_normalizer_if #(.Width(2))  if2 ();

  assign if24.valid_i = valid_i;
  assign if24.mode_i  = mode_i;
  assign if24.ready_i = ready_i;
  assign if24.data_i  = din[23:0];
  assign if53.valid_i = valid_i;
  assign if53.mode_i  = mode_i;
  assign if53.ready_i = ready_i;
  assign if53.data_i  = din[52:0];
  assign if2.valid_i  = valid_i;
  assign if2.mode_i   = mode_i;
  assign if2.ready_i  = ready_i;
  assign if2.data_i   = din[1:0];

  zero_count_normalizer #(.Width(24)) u24 (
    .clk(clk), .reset(reset), .bus(if24)
  );
  zero_count_normalizer #(.Width(53)) u53 (
    .clk(clk), .reset(reset), .bus(if53)
  );
  zero_count_normalizer #(.Width(2)) u2 (
    .clk(clk), .reset(reset), .bus(if2)
  );

  typedef struct packed {
    logic [63:0] c;
    logic [63:0] s;
    logic        z;
    logic        m;
  } res_t;

  res_t q24[$];
  res_t q53[$];
  res_t q2[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input int w,
                                 input logic [63:0] d,
                                 input logic m);
    res_t r;
    logic [63:0] mask;
    int k;
    mask = (64'd1 << w) - 64'd1;
    d = d & mask;
    r.m = m;
    r.z = (d == 64'd0);
    if (d == 64'd0) begin
      r.c = 64'(w);
      r.s = 64'd0;
    end else if (!m) begin
      k = 0;
      while (!d[k]) k++;
      r.c = 64'(k);
      r.s = d >> k;
    end else begin
      k = w - 1;
      while (!d[k]) k--;
      r.c = 64'(w - 1 - k);
      r.s = (d << (w - 1 - k)) & mask;
    end
    return r;
  endfunction

  task automatic cmp(input string t, input logic [63:0] c,
                     input logic [63:0] s, input logic z,
                     input logic m, input res_t e);
    chk({t, "_cnt"}, c, e.c);
    chk({t, "_shf"}, s, e.s);
    chk({t, "_zero"}, 64'(z), 64'(e.z));
    chk({t, "_mode"}, 64'(m), 64'(e.m));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid_i && if24.ready_o) q24.push_back(model(24, din, mode_i));
      if (valid_i && if53.ready_o) q53.push_back(model(53, din, mode_i));
      if (valid_i && if2.ready_o)  q2.push_back(model(2, din, mode_i));
      if (if24.valid_o && ready_i) begin
        if (q24.size() == 0) chk("extra24", 64'd1, 64'd0);
        else cmp("sb24", 64'(if24.count_o), 64'(if24.shifted_o),
                 if24.zero_o, if24.mode_o, q24.pop_front());
      end
      if (if53.valid_o && ready_i) begin
        if (q53.size() == 0) chk("extra53", 64'd1, 64'd0);
        else cmp("sb53", 64'(if53.count_o), 64'(if53.shifted_o),
                 if53.zero_o, if53.mode_o, q53.pop_front());
      end
      if (if2.valid_o && ready_i) begin
        if (q2.size() == 0) chk("extra2", 64'd1, 64'd0);
        else cmp("sb2", 64'(if2.count_o), 64'(if2.shifted_o),
                 if2.zero_o, if2.mode_o, q2.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic m);
    int g;
    logic r;
    g = 0;
    valid_i = 1'b1;
    din = d;
    mode_i = m;
    do begin
      @(negedge clk);
      r = if24.ready_o;
      @(posedge clk);
      #1;
      g++;
    end while (!r && g < 50);
    if (!r) chk("send_timeout", 64'd0, 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic dir(input logic [63:0] d, input logic m,
                     input logic [63:0] c24, input logic [63:0] s24,
                     input logic [63:0] c53,
                     input logic [63:0] c2, input logic [63:0] s2);
    valid_i = 1'b1;
    din = d;
    mode_i = m;
    tick();
    valid_i = 1'b0;
    chk("lat_early", 64'(if24.valid_o), 64'd0);
    tick();
    chk("d_valid", 64'(if24.valid_o), 64'd1);
    chk("d_cnt24", 64'(if24.count_o), c24);
    chk("d_shf24", 64'(if24.shifted_o), s24);
    chk("d_zero24", 64'(if24.zero_o), 64'(d[23:0] == 24'd0));
    chk("d_mode24", 64'(if24.mode_o), 64'(m));
    chk("d_cnt53", 64'(if53.count_o), c53);
    chk("d_cnt2", 64'(if2.count_o), c2);
    chk("d_shf2", 64'(if2.shifted_o), s2);
    tick();
  endtask

  logic [63:0] words [8] = '{
    64'h0000_0000_0040_0000, 64'h001F_0000_0000_8000,
    64'h0000_0000_0000_0003, 64'h0000_0000_0000_0000,
    64'h0010_0000_00F0_0001, 64'h0000_0123_4500_0000,
    64'h0000_0000_0080_0000, 64'h0008_0000_0000_0002
  };

  initial begin
    #200000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] sc, ss;
    logic        sz, sm;

    reset = 1'b1;
    valid_i = 1'b0;
    mode_i = 1'b0;
    ready_i = 1'b1;
    din = 64'd0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", 64'(if24.valid_o), 64'd0);
    chk("rst_cnt", 64'(if24.count_o), 64'd0);
    chk("rst_shf", 64'(if24.shifted_o), 64'd0);
    chk("rst_zero", 64'(if24.zero_o), 64'd0);
    chk("rst_mode", 64'(if24.mode_o), 64'd0);
    chk("rst_ready", 64'(if24.ready_o), 64'd1);

    dir(64'h000100, 1'b0, 8, 24'h000001, 8, 2, 0);
    dir(64'h000100, 1'b1, 15, 24'h800000, 44, 2, 0);
    dir(64'h800000, 1'b0, 23, 24'h000001, 23, 2, 0);
    dir(64'h000001, 1'b1, 23, 24'h800000, 52, 1, 2);
    dir(64'hFFFFFF, 1'b1, 0, 24'hFFFFFF, 29, 0, 3);
    dir(64'h000001, 1'b0, 0, 24'h000001, 0, 0, 1);
    dir(64'h000002, 1'b0, 1, 24'h000001, 1, 1, 1);
    dir(64'h0010_0000_0000_0000, 1'b1, 24, 0, 0, 2, 0);

    valid_i = 1'b1;
    din = 64'd0;
    mode_i = 1'b0;
    tick();
    mode_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("z0_valid", 64'(if24.valid_o), 64'd1);
    chk("z0_cnt", 64'(if24.count_o), 64'd24);
    chk("z0_zero", 64'(if24.zero_o), 64'd1);
    chk("z0_shf", 64'(if24.shifted_o), 64'd0);
    chk("z0_mode", 64'(if24.mode_o), 64'd0);
    tick();
    chk("z1_valid", 64'(if24.valid_o), 64'd1);
    chk("z1_cnt", 64'(if24.count_o), 64'd24);
    chk("z1_zero", 64'(if24.zero_o), 64'd1);
    chk("z1_mode", 64'(if24.mode_o), 64'd1);
    chk("z1_cnt2", 64'(if2.count_o), 64'd2);
    tick();

    fork
      begin
        for (int k = 0; k < 8; k++) send(words[k], 1'($urandom_range(1)));
      end
      begin
        repeat (3) tick();
        ready_i = 1'b0;
        chk("stall_valid", 64'(if24.valid_o), 64'd1);
        sc = 64'(if24.count_o);
        ss = 64'(if24.shifted_o);
        sz = if24.zero_o;
        sm = if24.mode_o;
        for (int k = 0; k < 4; k++) begin
          tick();
          chk("hold_valid", 64'(if24.valid_o), 64'd1);
          chk("hold_cnt", 64'(if24.count_o), sc);
          chk("hold_shf", 64'(if24.shifted_o), ss);
          chk("hold_zero", 64'(if24.zero_o), 64'(sz));
          chk("hold_mode", 64'(if24.mode_o), 64'(sm));
        end
        chk("stall_ready", 64'(if24.ready_o), 64'd0);
        ready_i = 1'b1;
      end
    join
    repeat (6) tick();
    chk("drain24", 64'(q24.size()), 64'd0);
    chk("drain53", 64'(q53.size()), 64'd0);
    chk("drain2", 64'(q2.size()), 64'd0);

    ready_i = 1'b0;
    send(64'h0000_0000_0000_0F00, 1'b1);
    send(64'h0000_0000_0000_0030, 1'b0);
    chk("pre_rst_valid", 64'(if24.valid_o), 64'd1);
    reset = 1'b1;
    q24.delete();
    q53.delete();
    q2.delete();
    tick();
    reset = 1'b0;
    chk("rst2_valid", 64'(if24.valid_o), 64'd0);
    chk("rst2_ready", 64'(if24.ready_o), 64'd1);
    chk("rst2_valid53", 64'(if53.valid_o), 64'd0);
    chk("rst2_valid2", 64'(if2.valid_o), 64'd0);
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_stale", 64'(if24.valid_o), 64'd0);
    end

    send(64'h0000_0000_0000_0401, 1'b1);
    send(64'h0000_0000_0040_0000, 1'b0);
    repeat (4) tick();
    chk("final24", 64'(q24.size()), 64'd0);
    chk("final53", 64'(q53.size()), 64'd0);
    chk("final2", 64'(q2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/zero_count_normalizer.md
Name: zero_count_normalizer

Overview:
- Pipelined, parametrised leading/trailing zero counter with integrated normalisation shift, for the FP adder/subtractor and the FP conversion datapath.
- Each input word is tagged with a per-transaction mode: count trailing zeros and right-shift them out, or count leading zeros and left-normalise.
- Two-stage valid/ready pipeline with full backpressure. Sits between the mantissa add/subtract stage and the rounding stage.

Parameters:
- Width, 24, operand width in bits (>= 2).
- CountWidth, $clog2(Width + 1), width of the count output (holds 0..Width).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_i  input  1  input word valid.
- ready_o  output  1  block can accept an input this cycle.
- data_i  input  Width  operand.
- mode_i  input  1  0 = trailing-zero mode, 1 = leading-zero mode.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- count_o  output  CountWidth  number of zeros counted.
- shifted_o  output  Width  normalised operand.
- zero_o  output  1  operand was all zeros.
- mode_o  output  1  mode of the transaction presented on the outputs.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - valid_o=0, count_o=0, shifted_o=0, zero_o=0, mode_o=0.
  - Both stage-valid flags cleared.
  - ready_o=1 on the first cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded, with no output pulse.
- Handshake:
  - An input transfer occurs when valid_i && ready_o.
  - An output transfer occurs when valid_o && ready_i.
  - While valid_o=1 && ready_i=0, count_o, shifted_o, zero_o and mode_o stay stable.
- Stage 1 (S1):
  - On transfer, registers data_i and mode_i.
  - Computes the count combinationally from the registered word.
  - Trailing mode: count = index of the lowest set bit.
  - Leading mode: count = (Width-1) - index of the highest set bit.
- Stage 2 (S2) registers:
  - count_o.
  - zero_o = ~|word.
  - mode_o.
  - shifted_o = word >> count in trailing mode, word << count in leading mode, zero-filled.
- Latency and throughput:
  - Latency is exactly 2 cycles from input transfer to valid_o with no stall.
  - Throughput is 1 transfer per cycle.
- Flow control:
  - s2_advance = ~valid_o | ready_i.
  - s1_advance = ~s1_valid | s2_advance.
  - ready_o = s1_advance, combinational from ready_i and the stage valids (no combinational path from valid_i).
  - S1 loads a new word when s1_advance.
  - S2 loads from S1 when s2_advance; S2 valid follows S1 valid on load.
- All-zero operand (either mode): count_o=Width, zero_o=1, shifted_o=0.
- Boundary results:
  - Trailing mode, data_i[0]=1: count 0.
  - Leading mode, data_i[Width-1]=1: count 0.
  - Leading mode, data_i=1: count Width-1, shifted_o has only the MSB set.
  - Trailing mode, data_i has only the MSB set: count Width-1, shifted_o=1.
- Simultaneous events:
  - Simultaneous input and output transfers in the same cycle are legal and must not lose or duplicate data.
  - Transactions retire strictly in order, each with its own mode.

Test Plan:
- Width=24, trailing, data_i=24'h000100 -> after 2 cycles: valid_o=1, count_o=8, shifted_o=24'h000001, zero_o=0, mode_o=0.
- Width=24, leading, data_i=24'h000100 -> count_o=15, shifted_o=24'h800000, zero_o=0, mode_o=1.
- data_i=0 in both modes, back-to-back -> two results on consecutive cycles, each count_o=24, zero_o=1, shifted_o=0, mode_o matching the input.
- Stream of 8 words with random mode, ready_i held 0 for 4 cycles mid-stream:
  - ready_o drops once both stages are full.
  - Outputs are held stable during the stall.
  - All 8 results arrive in order and match the reference model.
- Assert reset while 2 transactions are in flight -> next cycle valid_o=0 and ready_o=1; no stale result ever appears.
- Boundary words: trailing 24'h800000 -> count 23; leading 24'h000001 -> count 23; leading 24'hFFFFFF -> count 0, shifted unchanged.
- Repeat the suite at Width=53 (double mantissa) and Width=2.
